// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only register front end: synchronises the pins, assembles
// 16-bit frames and commits valid writes into five 8-bit control registers.
module spi_peripheral #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_copi_sync, r_ncs_sync;
    logic       r_sclk_prev, r_ncs_prev, r_copi_dly;
    logic       r_sclk_rise, r_ncs_rise, r_ncs_fall;
    logic [1:0] r_init_cnt;
    logic       r_armed;
    state_t     r_state, w_state_nxt;
    logic [15:0] r_shift;
    logic [4:0]  r_count;
    logic        r_fall_pend;
    logic [7:0]  r_reg0, r_reg1, r_reg2, r_reg3, r_reg4;
    logic        r_wr_strobe, r_frame_err;

    logic w_sclk_s, w_ncs_s, w_copi_s;
    logic w_clear, w_shift_en, w_wr, w_err, w_pend_set, w_pend_clr, w_frame_ok;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_copi_s = r_copi_sync[SYNC_STAGES-1];
    assign w_ncs_s  = r_ncs_sync[SYNC_STAGES-1];

    // Pin synchronisers and the edge-detect history flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= {SYNC_STAGES{1'b0}};
            r_copi_sync <= {SYNC_STAGES{1'b0}};
            r_ncs_sync  <= {SYNC_STAGES{1'b1}};
            r_sclk_prev <= 1'b0;
            r_ncs_prev  <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
            r_sclk_prev <= w_sclk_s;
            r_ncs_prev  <= w_ncs_s;
        end
    end

    // Registered edge events; copi is delayed alongside so it stays aligned.
    // A falling ncs only counts once a genuine high level has been seen after
    // reset, so ncs held low through reset release never starts a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_rise <= 1'b0;
            r_ncs_rise  <= 1'b0;
            r_ncs_fall  <= 1'b0;
            r_copi_dly  <= 1'b0;
            r_init_cnt  <= 2'd0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_rise <= w_sclk_s & ~r_sclk_prev;
            r_ncs_rise  <= w_ncs_s & ~r_ncs_prev;
            r_ncs_fall  <= ~w_ncs_s & r_ncs_prev & r_armed;
            r_copi_dly  <= w_copi_s;
            if (r_init_cnt != 2'(SYNC_STAGES)) begin
                r_init_cnt <= r_init_cnt + 2'd1;
            end
            if ((r_init_cnt == 2'(SYNC_STAGES)) && w_ncs_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_frame_ok = (r_count == 5'd16) && r_shift[15] && (r_shift[14:8] <= MAX_ADDR);

    // Frame FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath controls
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_shift_en  = 1'b0;
        w_wr        = 1'b0;
        w_err       = 1'b0;
        w_pend_set  = 1'b0;
        w_pend_clr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_ncs_fall || r_fall_pend) begin
                    w_state_nxt = ST_SHIFT;
                    w_clear     = 1'b1;
                    w_pend_clr  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_ncs_rise) begin
                    w_state_nxt = ST_COMMIT;
                end else if (r_sclk_rise) begin
                    w_shift_en = 1'b1;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
                w_pend_set  = r_ncs_fall;
                if (w_frame_ok) begin
                    w_wr = 1'b1;
                end else begin
                    w_err = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shift register, saturating bit counter and deferred chip-select fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= 16'h0000;
            r_count     <= 5'd0;
            r_fall_pend <= 1'b0;
        end else begin
            if (w_clear) begin
                r_shift <= 16'h0000;
                r_count <= 5'd0;
            end else if (w_shift_en) begin
                r_shift <= {r_shift[14:0], r_copi_dly};
                r_count <= (r_count == 5'd17) ? 5'd17 : (r_count + 5'd1);
            end
            if (w_pend_set) begin
                r_fall_pend <= 1'b1;
            end else if (w_pend_clr) begin
                r_fall_pend <= 1'b0;
            end
        end
    end

    // Control registers and the commit/error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg0      <= 8'h00;
            r_reg1      <= 8'h00;
            r_reg2      <= 8'h00;
            r_reg3      <= 8'h00;
            r_reg4      <= 8'h00;
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_strobe <= w_wr;
            r_frame_err <= w_err;
            if (w_wr) begin
                case (r_shift[14:8])
                    7'd0:    r_reg0 <= r_shift[7:0];
                    7'd1:    r_reg1 <= r_shift[7:0];
                    7'd2:    r_reg2 <= r_shift[7:0];
                    7'd3:    r_reg3 <= r_shift[7:0];
                    7'd4:    r_reg4 <= r_shift[7:0];
                    default: ;
                endcase
            end
        end
    end

    assign en_reg_out_7_0  = r_reg0;
    assign en_reg_out_15_8 = r_reg1;
    assign en_reg_pwm_7_0  = r_reg2;
    assign en_reg_pwm_15_8 = r_reg3;
    assign pwm_duty_cycle  = r_reg4;
    assign wr_strobe       = r_wr_strobe;
    assign frame_err       = r_frame_err;
endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral: frames push expected commit events,
// a monitor pops them whenever wr_strobe or frame_err pulses.
module tb_spi_peripheral;
    localparam int H = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic copi = 1'b0;
    logic ncs = 1'b1;
    logic [7:0] r0, r1, r2, r3, r4;
    logic wr_strobe, frame_err;

    spi_peripheral dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
        .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4),
        .wr_strobe(wr_strobe), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] cyc;
        logic [39:0] regs;
    } exp_t;
    exp_t q[$];
    logic [7:0] m_reg[5];

    function automatic logic [39:0] model_regs();
        return {m_reg[4], m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every output pulse must match the oldest expected event
    always @(negedge clk) begin
        if (rst_n && (wr_strobe || frame_err)) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", {62'd0, wr_strobe, frame_err}, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse_kind", {62'd0, wr_strobe, frame_err}, e.is_wr ? 64'd2 : 64'd1);
                check("latency", 64'(cyc), 64'(e.cyc));
                check("regs", {24'd0, r4, r3, r2, r1, r0}, {24'd0, e.regs});
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [16:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = v[i];
            wait_clk(H);
            sclk = 1'b1;
            wait_clk(H);
            sclk = 1'b0;
        end
    endtask

    // Caller is always at a falling clk edge on entry and exit
    task automatic frame(input logic [16:0] v, input int n, input bit exp_wr, input int gap);
        exp_t e;
        ncs = 1'b0;
        wait_clk(H);
        send_bits(v, n);
        wait_clk(H);
        if (exp_wr) m_reg[v[10:8]] = v[7:0];
        e.is_wr = exp_wr;
        e.cyc   = 32'(cyc + 5);
        e.regs  = model_regs();
        q.push_back(e);
        ncs = 1'b1;
        wait_clk(gap);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(10);
        check("rst_reg0", {56'd0, r0}, 64'h00);
        check("rst_reg1", {56'd0, r1}, 64'h00);
        check("rst_reg2", {56'd0, r2}, 64'h00);
        check("rst_reg3", {56'd0, r3}, 64'h00);
        check("rst_reg4", {56'd0, r4}, 64'h00);
        check("rst_wr_strobe", {63'd0, wr_strobe}, 64'd0);
        check("rst_frame_err", {63'd0, frame_err}, 64'd0);

        frame(17'h080F0, 16, 1'b1, 100);
        frame(17'h08480, 16, 1'b1, 100);
        frame(17'h08201, 16, 1'b1, 100);
        frame(17'h004AA, 16, 1'b0, 100);
        frame(17'h085FF, 16, 1'b0, 100);
        frame(17'h00801, 12, 1'b0, 100);
        frame(17'h08122, 16, 1'b1, 100);
        frame(17'h10267, 17, 1'b0, 100);

        // Reset mid-frame, released while ncs is still low
        ncs = 1'b0;
        wait_clk(H);
        send_bits(17'h00083, 8);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
        wait_clk(5);
        check("midreset_regs", {24'd0, r4, r3, r2, r1, r0}, {24'd0, model_regs()});
        rst_n = 1'b1;
        wait_clk(20);
        send_bits(17'h00001, 1);
        wait_clk(H);
        ncs = 1'b1;
        wait_clk(100);
        frame(17'h08355, 16, 1'b1, 100);

        // Back-to-back frames with short chip-select high gaps
        frame(17'h080A5, 16, 1'b1, 3);
        frame(17'h08466, 16, 1'b1, 1);
        frame(17'h0815A, 16, 1'b1, 100);

        for (int t = 0; t < 200 && q.size() != 0; t++) wait_clk(1);
        check("pending_events", 64'(q.size()), 64'd0);
        check("final_regs", {24'd0, r4, r3, r2, r1, r0}, {24'd0, model_regs()});
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
